// File: rtl/memory_pkg.sv
// Shared types and default sizing for the memory_array block.
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/memory_clear_fsm.sv
// Clear sequencer: walks clr_addr over every location once after reset,
// then parks in READY. State is exported so it can be observed directly.
module memory_clear_fsm
  import memory_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output state_t        state,
  output logic [AW-1:0] clr_addr,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_next;
  logic [AW-1:0] clr_addr_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    busy          = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_next    = READY;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr + AW'(1);
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/memory_array.sv
// Single-port-address memory with a self-clearing sequence and a 1 or 2 cycle
// read pipeline. Define MEMORY_FWD_EN for write-first same-address reads.
module memory_array
  import memory_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               DEPTH    = DEF_DEPTH,
  parameter int               RD_LAT   = DEF_RD_LAT,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         mem_in,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     memory_w_en,
  input  logic                     memory_r_en,
  output logic [WIDTH-1:0]         mem_out,
  output logic                     mem_out_valid,
  output logic                     busy,
  output logic                     addr_err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state;
  logic [AW-1:0]    clr_addr;
  logic             ready;
  logic             in_range;
  logic             wr_req;
  logic             rd_req;
  logic             clr_we;
  logic [WIDTH-1:0] rd_word;

  memory_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .state    (state),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // Non power-of-two depths leave part of the address space unbacked.
  assign ready    = (state == READY);
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign wr_req   = ready & memory_w_en & in_range;
  assign rd_req   = ready & memory_r_en;
  assign clr_we   = busy & rst_n;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else if (wr_req) begin
      mem[addr] <= mem_in;
    end
  end

  // Data is captured at acceptance, so later writes never disturb a read
  // already in the pipeline.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[addr];
`ifdef MEMORY_FWD_EN
      if (memory_w_en) begin
        rd_word = mem_in;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= ready & (memory_w_en | memory_r_en) & ~in_range;
    end
  end

  // Valid/data handshake: mem_out_valid is a single-cycle strobe, mem_out
  // changes only alongside it and otherwise holds the last delivered word.
  if (RD_LAT == 2) begin : g_lat2
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_valid      <= 1'b0;
        s1_data       <= '0;
        mem_out_valid <= 1'b0;
        mem_out       <= '0;
      end else begin
        s1_valid      <= rd_req;
        mem_out_valid <= s1_valid;
        if (rd_req) begin
          s1_data <= rd_word;
        end
        if (s1_valid) begin
          mem_out <= s1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mem_out_valid <= 1'b0;
        mem_out       <= '0;
      end else begin
        mem_out_valid <= rd_req;
        if (rd_req) begin
          mem_out <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_array.sv
// Bench for memory_array: one DEPTH=256/RD_LAT=1 instance and one
// DEPTH=200/RD_LAT=2 instance driven with the same stimulus.
module tb_memory_array;

  logic       clk;
  logic       rst_n;
  logic [7:0] mem_in;
  logic [7:0] addr;
  logic       memory_w_en;
  logic       memory_r_en;

  logic [7:0] out_d  [2];
  logic       out_v  [2];
  logic       busy_o [2];
  logic       err_o  [2];

  memory_array #(.WIDTH(8), .DEPTH(256), .RD_LAT(1), .INIT_VAL(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .mem_in(mem_in), .addr(addr),
    .memory_w_en(memory_w_en), .memory_r_en(memory_r_en),
    .mem_out(out_d[0]), .mem_out_valid(out_v[0]), .busy(busy_o[0]), .addr_err(err_o[0])
  );

  memory_array #(.WIDTH(8), .DEPTH(200), .RD_LAT(2), .INIT_VAL(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .mem_in(mem_in), .addr(addr),
    .memory_w_en(memory_w_en), .memory_r_en(memory_r_en),
    .mem_out(out_d[1]), .mem_out_valid(out_v[1]), .busy(busy_o[1]), .addr_err(err_o[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // scoreboard state
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         depth_c [2] = '{256, 200};
  int         lat_c   [2] = '{1, 2};
  int         busy_left [2];
  int         busy_seen [2];
  logic       exp_err   [2];
  logic [7:0] last_out  [2];
  logic [7:0] model [2][256];

  logic [7:0] exp_q [$];
  int         due_q [$];
  int         id_q  [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int find_id(input int k);
    for (int i = 0; i < id_q.size(); i++) begin
      if (id_q[i] == k) return i;
    end
    return -1;
  endfunction

  task automatic purge(input int k);
    for (int i = id_q.size() - 1; i >= 0; i--) begin
      if (id_q[i] == k) begin
        exp_q.delete(i);
        due_q.delete(i);
        id_q.delete(i);
      end
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at
  // the next falling edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] a,
                       input logic [7:0] d, input logic rst);
    logic       in_rng;
    logic [7:0] rd;
    int         idx;
    rst_n       = rst;
    memory_w_en = w;
    memory_r_en = r;
    addr        = a;
    mem_in      = d;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("busy%0d", k), busy_o[k], busy_left[k] != 0);
      if (!rst) begin
        busy_left[k] = depth_c[k];
        busy_seen[k] = 0;
        exp_err[k]   = 1'b0;
        last_out[k]  = 8'h00;
        purge(k);
        for (int j = 0; j < 256; j++) model[k][j] = 8'h00;
      end else if (busy_left[k] != 0) begin
        if (busy_o[k] === 1'b1) busy_seen[k]++;
        busy_left[k]--;
        exp_err[k] = 1'b0;
      end else begin
        in_rng     = (int'(a) < depth_c[k]);
        exp_err[k] = (w | r) & ~in_rng;
        if (r) begin
          rd = in_rng ? model[k][a] : 8'h00;
`ifdef MEMORY_FWD_EN
          if (w && in_rng) rd = d;
`endif
          exp_q.push_back(rd);
          due_q.push_back(cyc + lat_c[k]);
          id_q.push_back(k);
        end
        if (w && in_rng) model[k][a] = d;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("addr_err%0d", k), err_o[k], exp_err[k]);
      idx = find_id(k);
      if (out_v[k] === 1'b1) begin
        if (idx < 0) begin
          check_val($sformatf("spurious_valid%0d", k), 1, 0);
        end else begin
          check_val($sformatf("rdata%0d", k), out_d[k], exp_q[idx]);
          check_val($sformatf("latency%0d", k), cyc, due_q[idx]);
          last_out[k] = exp_q[idx];
          exp_q.delete(idx);
          due_q.delete(idx);
          id_q.delete(idx);
        end
      end else begin
        if (idx >= 0 && due_q[idx] <= cyc) begin
          check_val($sformatf("missing_valid%0d", k), 0, 1);
          exp_q.delete(idx);
          due_q.delete(idx);
          id_q.delete(idx);
        end
        check_val($sformatf("hold%0d", k), out_d[k], last_out[k]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b0, a, d, 1'b1);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b0, 1'b1, a, 8'h00, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    memory_w_en = 1'b0;
    memory_r_en = 1'b0;
    addr        = 8'h00;
    mem_in      = 8'h00;
    for (int k = 0; k < 2; k++) begin
      busy_left[k] = depth_c[k];
      busy_seen[k] = 0;
      exp_err[k]   = 1'b0;
      last_out[k]  = 8'h00;
    end
    repeat (2) @(negedge clk);

    // reset state, then the first clear with requests issued while busy
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 260; i++) begin
      if (i == 10)      cycle(1'b1, 1'b1, 8'h02, 8'hEE, 1'b1);
      else if (i == 20) cycle(1'b1, 1'b1, 8'hC8, 8'h99, 1'b1);
      else              idle(1);
    end
    check_val("busy_cycles0", busy_seen[0], 256);
    check_val("busy_cycles1", busy_seen[1], 200);

    // cleared contents, including the location written while busy
    rd(8'h00);
    rd(8'hFF);
    rd(8'h02);
    idle(2);

    // write then read back
    wr(8'h10, 8'hA5);
    rd(8'h10);
    idle(2);

    // same-address read during write
    wr(8'h20, 8'h3C);
    cycle(1'b1, 1'b1, 8'h20, 8'h77, 1'b1);
    rd(8'h20);
    idle(2);

    // out-of-range on the 200-deep instance
    wr(8'hC8, 8'h55);
    rd(8'hC8);
    idle(2);

    // back-to-back reads
    wr(8'h01, 8'h11);
    wr(8'h02, 8'h22);
    wr(8'h03, 8'h33);
    rd(8'h01);
    rd(8'h02);
    rd(8'h03);
    idle(3);

    // independent read/write, and a write right after a read
    cycle(1'b1, 1'b1, 8'h40, 8'h09, 1'b1);
    rd(8'h40);
    rd(8'h30);
    wr(8'h30, 8'hB4);
    rd(8'h30);
    idle(3);

    // mixed random traffic
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    end
    idle(3);

    // reset with reads in flight, then a clear interrupted by a second reset
    wr(8'h10, 8'hA5);
    rd(8'h10);
    rd(8'h10);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 320; i++) begin
      if (i == 50) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      else         idle(1);
    end
    rd(8'h10);
    rd(8'h02);
    idle(4);
    check_val("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
